// File: rtl/serial_adder_ctrl_if.sv
// Operand/result handshake bundle for serial_adder_ctrl.
// Signal names are taken from the adder's point of view (i_* flows into it, o_* out of it).
//   i_valid/o_ready         : operand channel handshake
//   i_op1/i_op2/i_cin       : operands and carry-in
//   o_valid/i_ready         : result channel handshake
//   o_sum/o_cout            : result and carry-out
//   o_busy                  : adder is not idle
// slave modport  : used by the adder.
// master modport : used by whatever feeds operands and drains results.
interface serial_adder_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] i_op1;
    logic [DATA_WIDTH-1:0] i_op2;
    logic                  i_cin;
    logic                  o_valid;
    logic                  i_ready;
    logic [DATA_WIDTH-1:0] o_sum;
    logic                  o_cout;
    logic                  o_busy;

    modport slave (
        input  i_valid, i_op1, i_op2, i_cin, i_ready,
        output o_ready, o_valid, o_sum, o_cout, o_busy
    );

    modport master (
        output i_valid, i_op1, i_op2, i_cin, i_ready,
        input  o_ready, o_valid, o_sum, o_cout, o_busy
    );
endinterface

// File: rtl/serial_adder_ctrl.sv
// Digit-serial adder sequencer plus its per-digit full adder.
//   full_adder        : combinational DATA_WIDTH-bit adder with carry in/out.
//   serial_adder_ctrl : accepts two operands and a carry-in, adds them one
//                       DIGIT_WIDTH digit per cycle LSB first, and returns sum
//                       and carry-out over a result handshake.
// serial_adder_ctrl ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset
//   bus    : serial_adder_ctrl_if.slave (operand and result channels, busy flag)

module full_adder #(
    parameter int unsigned DATA_WIDTH = 2
) (
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  cin_i,
    output logic [DATA_WIDTH-1:0] sum_o,
    output logic                  cout_o
);
    localparam int unsigned SUM_W = DATA_WIDTH + 1;

    assign {cout_o, sum_o} = SUM_W'(a_i) + SUM_W'(b_i) + SUM_W'(cin_i);
endmodule

module serial_adder_ctrl #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DIGIT_WIDTH = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    serial_adder_ctrl_if.slave  bus
);
    localparam int unsigned N     = DATA_WIDTH / DIGIT_WIDTH;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    // Operand width must split into whole digits.
    if ((DATA_WIDTH % DIGIT_WIDTH) != 0) begin : g_bad_width
        $error("serial_adder_ctrl: DATA_WIDTH must be a multiple of DIGIT_WIDTH");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   carry_q;
    logic [DATA_WIDTH-1:0]  op1_q;
    logic [DATA_WIDTH-1:0]  op2_q;
    logic                   valid_q;
    logic [DATA_WIDTH-1:0]  sum_q;
    logic                   cout_q;

    logic [DIGIT_WIDTH-1:0] fa_sum;
    logic                   fa_cout;
    logic [DATA_WIDTH-1:0]  res_d;

    // One digit of the addition per ADD cycle.
    full_adder #(
        .DATA_WIDTH (DIGIT_WIDTH)
    ) u_full_adder (
        .a_i    (op1_q[DIGIT_WIDTH-1:0]),
        .b_i    (op2_q[DIGIT_WIDTH-1:0]),
        .cin_i  (carry_q),
        .sum_o  (fa_sum),
        .cout_o (fa_cout)
    );

    // Result shift register: new digit enters at the MSB end; only the
    // upper DATA_WIDTH-DIGIT_WIDTH bits need storing between cycles, so
    // res_d is the fully shifted result including the current digit.
    if (N > 1) begin : g_multi_digit
        logic [DATA_WIDTH-DIGIT_WIDTH-1:0] part_q;

        assign res_d = {fa_sum, part_q};

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                part_q <= '0;
            end else if (state_q == ADD) begin
                part_q <= res_d[DATA_WIDTH-1:DIGIT_WIDTH];
            end
        end
    end else begin : g_single_digit
        assign res_d = fa_sum;
    end

    // Sequencer: IDLE accepts, ADD walks the digits, DONE holds the result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            op1_q   <= '0;
            op2_q   <= '0;
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_valid) begin
                        op1_q   <= bus.i_op1;
                        op2_q   <= bus.i_op2;
                        carry_q <= bus.i_cin;
                        cnt_q   <= '0;
                        state_q <= ADD;
                    end
                end
                ADD: begin
                    op1_q   <= op1_q >> DIGIT_WIDTH;
                    op2_q   <= op2_q >> DIGIT_WIDTH;
                    carry_q <= fa_cout;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(N - 1)) begin
                        sum_q   <= res_d;
                        cout_q  <= fa_cout;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Ready drops in the reset cycle itself so nothing is accepted under reset.
    assign bus.o_ready = (state_q == IDLE) && !i_rst;
    assign bus.o_valid = valid_q;
    assign bus.o_sum   = sum_q;
    assign bus.o_cout  = cout_q;
    assign bus.o_busy  = (state_q != IDLE);
endmodule
